// File: rtl/mem_pkg.sv
// Shared constants for the memory unit, control unit and assembler tests.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] OP_NO  = 8'hFF;
  localparam logic [7:0] OP_HLT = 8'hFA;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM; a write also returns its data on the read port.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata_q   <= wdata;
    end else begin
      rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_unit.sv
// Memory responder for the control unit with a boot loader that streams bytes in,
// pads the rest with HLT, then releases the RAM to the control unit.
module mem_unit
  import mem_pkg::*;
#(
  parameter int                 ADDR_W        = 8,
  parameter int                 DATA_W        = 8,
  parameter logic [DATA_W-1:0]  FILL_BYTE     = DATA_W'(OP_HLT),
  parameter logic [DATA_W-1:0]  NOP_BYTE      = DATA_W'(OP_NO),
  parameter bit                 LOAD_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] to_mem,
  input  logic              mem_write,
  output logic [DATA_W-1:0] from_mem,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              load_done
);

  localparam state_e            RST_ST  = LOAD_ON_RESET ? ST_LOAD : ST_RUN;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rd_run_q, rd_run_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign load_ready = (state_q == ST_LOAD);
  assign cpu_hold   = (state_q == ST_LOAD) || (state_q == ST_FILL);
  assign load_done  = (state_q == ST_RUN);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ram_we    = 1'b0;
    ram_addr  = ptr_q;
    ram_wdata = load_data;
    unique case (state_q)
      ST_LOAD: begin
        if (load_valid) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          // A full RAM ends the stream whether or not last was flagged.
          if (ptr_q == PTR_MAX) state_d = ST_RUN;
          else if (load_last)   state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        ram_we    = 1'b1;
        ram_wdata = FILL_BYTE;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == PTR_MAX) state_d = ST_RUN;
      end
      default: begin
        ram_we    = mem_write;
        ram_addr  = address;
        ram_wdata = to_mem;
      end
    endcase
  end

  // Qualifies the registered RAM output: only reads launched in RUN reach the CPU.
  assign rd_run_d = (state_q == ST_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RST_ST;
      ptr_q    <= '0;
      rd_run_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rd_run_q <= rd_run_d;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign from_mem = rd_run_q ? ram_rdata : NOP_BYTE;

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: boot load, fill, RUN reads/writes and reset mid-fill.
module tb_mem_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] address, to_mem, from_mem, load_data;
  logic       mem_write, load_valid, load_last;
  logic       load_ready, cpu_hold, load_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_unit dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .address    (address),
    .to_mem     (to_mem),
    .mem_write  (mem_write),
    .from_mem   (from_mem),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_ready", load_ready, 1);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", load_done, 0);
    chk("rst_from_mem", from_mem, 8'hFF);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Bounded wait for RUN; returns edges spent holding and whether from_mem stayed NOP.
  task automatic wait_run(output int n, output bit nop_ok);
    n = 0;
    nop_ok = 1'b1;
    while (cpu_hold && n < 400) begin
      tick();
      n++;
      if (cpu_hold && from_mem !== 8'hFF) nop_ok = 1'b0;
    end
    if (cpu_hold) chk("run_timeout", 1, 0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    address   = a;
    mem_write = 1'b0;
    tick();
    chk(tag, from_mem, exp);
  endtask

  int n;
  bit nop_ok;

  initial begin
    reset_n = 1'b0; address = '0; to_mem = '0; mem_write = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    #12;

    // 3-byte stream, then 253 fill cycles
    do_reset();
    send(8'h91, 0);
    send(8'h40, 0);
    chk("t1_ready_mid", load_ready, 1);
    send(8'hFA, 1);
    chk("t1_ready_after", load_ready, 0);
    chk("t1_hold_fill", cpu_hold, 1);
    wait_run(n, nop_ok);
    chk("t1_fill_cycles", n, 253);
    chk("t1_nop_hold", nop_ok, 1);
    chk("t1_done", load_done, 1);
    load_valid = 1'b1;
    #1;
    chk("t1_ready_run", load_ready, 0);
    load_valid = 1'b0;
    rd(8'h00, 8'h91, "t1_rd0");
    rd(8'h01, 8'h40, "t1_rd1");
    rd(8'h02, 8'hFA, "t1_rd2");
    rd(8'h03, 8'hFA, "t1_rd3");
    rd(8'hFF, 8'hFA, "t1_rd255");

    // sparse valid: only valid edges advance ptr
    do_reset();
    nop_ok = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), i == 4);
      if (from_mem !== 8'hFF) nop_ok = 1'b0;
      if (i != 4) begin
        tick();
        if (from_mem !== 8'hFF) nop_ok = 1'b0;
      end
    end
    chk("t2_nop_load", nop_ok, 1);
    wait_run(n, nop_ok);
    chk("t2_fill_cycles", n, 252);
    chk("t2_nop_fill", nop_ok, 1);
    rd(8'h00, 8'h01, "t2_rd0");
    rd(8'h03, 8'h04, "t2_rd3");
    rd(8'h04, 8'hFA, "t2_rd4");

    // full 256-byte stream, implicit last
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 0);
      if (i == 254) chk("t3_ready_254", load_ready, 1);
    end
    chk("t3_done_nofill", load_done, 1);
    chk("t3_hold", cpu_hold, 0);
    rd(8'hFF, 8'hFF, "t3_rd255");
    rd(8'h00, 8'h00, "t3_rd0");

    // RUN write-first
    address = 8'h20; to_mem = 8'h5A; mem_write = 1'b1;
    tick();
    chk("t4_wr_first", from_mem, 8'h5A);
    rd(8'h20, 8'h5A, "t4_rd20");
    rd(8'h21, 8'h21, "t4_rd21");

    // reset 10 cycles into FILL
    do_reset();
    send(8'hAA, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_in_fill", cpu_hold, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_ready", load_ready, 1);
    chk("t5_async_nop", from_mem, 8'hFF);
    @(negedge clock);
    reset_n = 1'b1;
    #1;

    // CPU write attempts in LOAD are ignored
    address = 8'h00; to_mem = 8'h77; mem_write = 1'b1;
    tick();
    tick();
    chk("t6_nop_cpu_wr", from_mem, 8'hFF);
    chk("t6_still_load", load_ready, 1);
    mem_write = 1'b0;
    send(8'hC3, 1);
    wait_run(n, nop_ok);
    chk("t5_fill_cycles", n, 255);
    chk("t5_nop_hold", nop_ok, 1);
    rd(8'h00, 8'hC3, "t5_rd0");
    rd(8'h01, 8'hFA, "t5_rd1");
    rd(8'h80, 8'hFA, "t5_rd128");
    rd(8'hFF, 8'hFA, "t5_rd255");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
